// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad PIN lock controller.
// State encodings double as the 7-segment stateCode shown to the user.
package lock_pkg;

  localparam int PIN_W = 16;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [2:0] {
    ST_LOCKED       = 3'd0,
    ST_CHECK        = 3'd1,
    ST_UNLOCKED     = 3'd2,
    ST_FAIL_HOLD    = 3'd3,
    ST_LOCKOUT      = 3'd4,
    ST_PROG_NEW     = 3'd5,
    ST_PROG_CONFIRM = 3'd6
  } state_t;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Keypad stays live only where the user is expected to type.
  function automatic logic statusOf(input state_t s);
    return !(s == ST_LOCKED || s == ST_PROG_NEW || s == ST_PROG_CONFIRM);
  endfunction

  function automatic logic unlockedOf(input state_t s);
    return (s == ST_UNLOCKED || s == ST_PROG_NEW || s == ST_PROG_CONFIRM);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by every timed state of the lock FSM.
// Holds at zero; expired is simply count==0.
module lock_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/lock_controller.sv
// PIN entry sequencer: checks entries against a volatile stored PIN, counts
// failures into a timed lockout, auto-relocks and supports PIN reprogramming.
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [PIN_W-1:0] DEFAULT_PIN    = 16'h1234,
  parameter int               MAX_ATTEMPTS   = 3,
  parameter int               FAIL_CYCLES    = 500,
  parameter int               UNLOCK_CYCLES  = 2500,
  parameter int               LOCKOUT_CYCLES = 15000,
  parameter int               PROG_CYCLES    = 5000
) (
  input  logic             clk_500Hz,
  input  logic             rst_n,
  input  logic             validPin,
  input  logic [PIN_W-1:0] userPin,
  input  logic             setMode,
  output logic             status,
  output logic             unlocked,
  output logic             lockedOut,
  output logic [3:0]       attemptsLeft,
  output logic [2:0]       stateCode,
  output logic             progDone,
  output logic             progErr
);

  localparam int MAX_T = maxOf(maxOf(FAIL_CYCLES, UNLOCK_CYCLES),
                               maxOf(LOCKOUT_CYCLES, PROG_CYCLES));
  localparam int TW = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] FAIL_LOAD    = TW'(FAIL_CYCLES - 1);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] PROG_LOAD    = TW'(PROG_CYCLES - 1);
  localparam logic [3:0]    ATTEMPTS_MAX = 4'(MAX_ATTEMPTS);

  state_t           r_state;
  logic [PIN_W-1:0] r_storedPin;
  logic [PIN_W-1:0] r_capReg;
  logic [PIN_W-1:0] r_newReg;
  logic [3:0]       r_attemptsLeft;
  logic             r_status;
  logic             r_unlocked;
  logic             r_lockedOut;
  logic [2:0]       r_stateCode;
  logic             r_progDone;
  logic             r_progErr;

  state_t           w_nextState;
  logic             w_timerLoad;
  logic [TW-1:0]    w_timerValue;
  logic             w_expired;
  logic [3:0]       w_nextAttempts;
  logic [3:0]       w_decAttempts;
  logic             w_capture;
  logic             w_captureNew;
  logic             w_commit;
  logic             w_progDone;
  logic             w_progErr;

  lock_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk_500Hz),
    .rst_n     (rst_n),
    .load      (w_timerLoad),
    .load_value(w_timerValue),
    .expired   (w_expired)
  );

  assign w_decAttempts = r_attemptsLeft - 4'd1;

  // Next-state decision; the timer is loaded on the same edge the timed state is entered.
  always_comb begin
    w_nextState    = r_state;
    w_timerLoad    = 1'b0;
    w_timerValue   = '0;
    w_nextAttempts = r_attemptsLeft;
    w_capture      = 1'b0;
    w_captureNew   = 1'b0;
    w_commit       = 1'b0;
    w_progDone     = 1'b0;
    w_progErr      = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (validPin) begin
          w_capture   = 1'b1;
          w_nextState = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_capReg == r_storedPin) begin
          w_nextState    = ST_UNLOCKED;
          w_nextAttempts = ATTEMPTS_MAX;
          w_timerLoad    = 1'b1;
          w_timerValue   = UNLOCK_LOAD;
        end else begin
          w_nextAttempts = w_decAttempts;
          w_timerLoad    = 1'b1;
          if (w_decAttempts == 4'd0) begin
            w_nextState  = ST_LOCKOUT;
            w_timerValue = LOCKOUT_LOAD;
          end else begin
            w_nextState  = ST_FAIL_HOLD;
            w_timerValue = FAIL_LOAD;
          end
        end
      end
      ST_FAIL_HOLD: begin
        if (w_expired) w_nextState = ST_LOCKED;
      end
      ST_LOCKOUT: begin
        if (w_expired) begin
          w_nextState    = ST_LOCKED;
          w_nextAttempts = ATTEMPTS_MAX;
        end
      end
      ST_UNLOCKED: begin
        if (setMode) begin
          w_nextState  = ST_PROG_NEW;
          w_timerLoad  = 1'b1;
          w_timerValue = PROG_LOAD;
        end else if (w_expired) begin
          w_nextState = ST_LOCKED;
        end
      end
      ST_PROG_NEW: begin
        if (!setMode) begin
          w_progErr   = 1'b1;
          w_nextState = ST_LOCKED;
        end else if (validPin) begin
          w_captureNew = 1'b1;
          w_nextState  = ST_PROG_CONFIRM;
          w_timerLoad  = 1'b1;
          w_timerValue = PROG_LOAD;
        end else if (w_expired) begin
          w_progErr   = 1'b1;
          w_nextState = ST_LOCKED;
        end
      end
      ST_PROG_CONFIRM: begin
        if (!setMode) begin
          w_progErr   = 1'b1;
          w_nextState = ST_LOCKED;
        end else if (validPin) begin
          w_nextState = ST_LOCKED;
          if (userPin == r_newReg) begin
            w_commit   = 1'b1;
            w_progDone = 1'b1;
          end else begin
            w_progErr = 1'b1;
          end
        end else if (w_expired) begin
          w_progErr   = 1'b1;
          w_nextState = ST_LOCKED;
        end
      end
      default: begin
        w_nextState = ST_LOCKED;
      end
    endcase
  end

  // Outputs are derived from the next state so they switch with the state register.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_LOCKED;
      r_storedPin    <= DEFAULT_PIN;
      r_capReg       <= '0;
      r_newReg       <= '0;
      r_attemptsLeft <= ATTEMPTS_MAX;
      r_status       <= 1'b0;
      r_unlocked     <= 1'b0;
      r_lockedOut    <= 1'b0;
      r_stateCode    <= 3'd0;
      r_progDone     <= 1'b0;
      r_progErr      <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_attemptsLeft <= w_nextAttempts;
      r_status       <= statusOf(w_nextState);
      r_unlocked     <= unlockedOf(w_nextState);
      r_lockedOut    <= (w_nextState == ST_LOCKOUT);
      r_stateCode    <= w_nextState;
      r_progDone     <= w_progDone;
      r_progErr      <= w_progErr;
      if (w_capture)    r_capReg    <= userPin;
      if (w_captureNew) r_newReg    <= userPin;
      if (w_commit)     r_storedPin <= r_newReg;
    end
  end

  assign status       = r_status;
  assign unlocked     = r_unlocked;
  assign lockedOut    = r_lockedOut;
  assign attemptsLeft = r_attemptsLeft;
  assign stateCode    = r_stateCode;
  assign progDone     = r_progDone;
  assign progErr      = r_progErr;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller using shortened timeouts.
// Expected values below are hand-derived cycle by cycle from the lock behaviour.
module tb_lock_controller;

  logic        clk_500Hz;
  logic        rst_n;
  logic        validPin;
  logic [15:0] userPin;
  logic        setMode;
  logic        status;
  logic        unlocked;
  logic        lockedOut;
  logic [3:0]  attemptsLeft;
  logic [2:0]  stateCode;
  logic        progDone;
  logic        progErr;

  int errorCount = 0;
  int checkCount = 0;

  lock_controller #(
    .DEFAULT_PIN   (16'h1234),
    .MAX_ATTEMPTS  (3),
    .FAIL_CYCLES   (4),
    .UNLOCK_CYCLES (8),
    .LOCKOUT_CYCLES(16),
    .PROG_CYCLES   (10)
  ) dut (
    .clk_500Hz   (clk_500Hz),
    .rst_n       (rst_n),
    .validPin    (validPin),
    .userPin     (userPin),
    .setMode     (setMode),
    .status      (status),
    .unlocked    (unlocked),
    .lockedOut   (lockedOut),
    .attemptsLeft(attemptsLeft),
    .stateCode   (stateCode),
    .progDone    (progDone),
    .progErr     (progErr)
  );

  initial clk_500Hz = 1'b0;
  always #5 clk_500Hz = ~clk_500Hz;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_500Hz);
    #1;
  endtask

  // Pulses validPin for exactly one clock with the given entry.
  task automatic applyStimulus(input logic [15:0] pin);
    validPin = 1'b1;
    userPin  = pin;
    tick(1);
    validPin = 1'b0;
    userPin  = 16'h0000;
  endtask

  task automatic expectCore(input string tag, input int code, input logic st,
                            input logic unl, input logic lo, input int att);
    checkOutput({tag, ".code"}, 32'(stateCode), 32'(code));
    checkOutput({tag, ".status"}, 32'(status), 32'(st));
    checkOutput({tag, ".unlocked"}, 32'(unlocked), 32'(unl));
    checkOutput({tag, ".lockedOut"}, 32'(lockedOut), 32'(lo));
    checkOutput({tag, ".attempts"}, 32'(attemptsLeft), 32'(att));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    errorCount++;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    validPin = 1'b0;
    userPin  = 16'h0000;
    setMode  = 1'b0;
    tick(2);
    expectCore("reset", 0, 0, 0, 0, 3);
    checkOutput("reset.progDone", 32'(progDone), 0);
    checkOutput("reset.progErr", 32'(progErr), 0);
    rst_n = 1'b1;
    tick(1);

    // Correct PIN and auto-relock
    applyStimulus(16'h1234);
    expectCore("ok.check", 1, 1, 0, 0, 3);
    tick(1);
    expectCore("ok.unlock", 2, 1, 1, 0, 3);
    tick(7);
    expectCore("ok.lastUnlocked", 2, 1, 1, 0, 3);
    tick(1);
    expectCore("ok.relock", 0, 0, 0, 0, 3);

    // Wrong PINs, frozen keypad during FAIL_HOLD and LOCKOUT
    applyStimulus(16'h0000);
    expectCore("bad1.check", 1, 1, 0, 0, 3);
    tick(1);
    expectCore("bad1.hold", 3, 1, 0, 0, 2);
    applyStimulus(16'h1234);
    expectCore("bad1.frozen", 3, 1, 0, 0, 2);
    tick(2);
    expectCore("bad1.holdEnd", 3, 1, 0, 0, 2);
    tick(1);
    expectCore("bad1.locked", 0, 0, 0, 0, 2);
    applyStimulus(16'h0000);
    tick(1);
    expectCore("bad2.hold", 3, 1, 0, 0, 1);
    tick(4);
    expectCore("bad2.locked", 0, 0, 0, 0, 1);
    applyStimulus(16'h0000);
    tick(1);
    expectCore("bad3.lockout", 4, 1, 0, 1, 0);
    applyStimulus(16'h1234);
    expectCore("bad3.frozen", 4, 1, 0, 1, 0);
    tick(14);
    expectCore("bad3.lockoutEnd", 4, 1, 0, 1, 0);
    tick(1);
    expectCore("bad3.released", 0, 0, 0, 0, 3);

    // Entry ignored while unlocked; relock timing unaffected
    applyStimulus(16'h1234);
    tick(1);
    applyStimulus(16'h0000);
    expectCore("frozenUnl.still", 2, 1, 1, 0, 3);
    tick(6);
    expectCore("frozenUnl.last", 2, 1, 1, 0, 3);
    tick(1);
    expectCore("frozenUnl.relock", 0, 0, 0, 0, 3);

    // Reprogram to 5678
    applyStimulus(16'h1234);
    tick(1);
    setMode = 1'b1;
    tick(1);
    expectCore("prog.new", 5, 0, 1, 0, 3);
    applyStimulus(16'h5678);
    expectCore("prog.confirm", 6, 0, 1, 0, 3);
    checkOutput("prog.confirmDone", 32'(progDone), 0);
    applyStimulus(16'h5678);
    expectCore("prog.done", 0, 0, 0, 0, 3);
    checkOutput("prog.donePulse", 32'(progDone), 1);
    checkOutput("prog.noErr", 32'(progErr), 0);
    setMode = 1'b0;
    tick(1);
    checkOutput("prog.donePulseEnd", 32'(progDone), 0);
    applyStimulus(16'h1234);
    tick(1);
    expectCore("prog.oldFails", 3, 1, 0, 0, 2);
    tick(4);
    applyStimulus(16'h5678);
    tick(1);
    expectCore("prog.newUnlocks", 2, 1, 1, 0, 3);

    // Confirm mismatch leaves stored PIN alone
    setMode = 1'b1;
    tick(1);
    applyStimulus(16'h5678);
    applyStimulus(16'h5679);
    expectCore("mis.locked", 0, 0, 0, 0, 3);
    checkOutput("mis.errPulse", 32'(progErr), 1);
    checkOutput("mis.noDone", 32'(progDone), 0);
    setMode = 1'b0;
    tick(1);
    checkOutput("mis.errPulseEnd", 32'(progErr), 0);
    applyStimulus(16'h5678);
    tick(1);
    expectCore("mis.storedKept", 2, 1, 1, 0, 3);

    // setMode drop in PROG_CONFIRM
    setMode = 1'b1;
    tick(1);
    applyStimulus(16'h1111);
    expectCore("abort.confirm", 6, 0, 1, 0, 3);
    setMode = 1'b0;
    tick(1);
    expectCore("abort.locked", 0, 0, 0, 0, 3);
    checkOutput("abort.errPulse", 32'(progErr), 1);
    tick(1);
    checkOutput("abort.errPulseEnd", 32'(progErr), 0);

    // setMode on the unlock expiry cycle, then programming timeout
    applyStimulus(16'h5678);
    tick(1);
    tick(7);
    expectCore("tmo.unlockLast", 2, 1, 1, 0, 3);
    setMode = 1'b1;
    tick(1);
    expectCore("tmo.setModeWins", 5, 0, 1, 0, 3);
    tick(9);
    expectCore("tmo.progLast", 5, 0, 1, 0, 3);
    checkOutput("tmo.noErrYet", 32'(progErr), 0);
    tick(1);
    expectCore("tmo.locked", 0, 0, 0, 0, 3);
    checkOutput("tmo.errPulse", 32'(progErr), 1);
    setMode = 1'b0;
    tick(1);
    checkOutput("tmo.errPulseEnd", 32'(progErr), 0);

    // Reset in the middle of lockout restores defaults
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0000);
      tick(1);
      if (i < 2) tick(4);
    end
    expectCore("rst.lockout", 4, 1, 0, 1, 0);
    tick(3);
    rst_n = 1'b0;
    #2;
    expectCore("rst.async", 0, 0, 0, 0, 3);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    applyStimulus(16'h1234);
    tick(1);
    expectCore("rst.defaultPin", 2, 1, 1, 0, 3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
Name: lock_controller

Overview:
- Sequencer for the keypad PIN entry path; sits between keypadDecode and the lock/display logic.
- Consumes the one-cycle validPin pulse and the 16-bit userPin (4 BCD digits), compares against a stored PIN, and tracks failed attempts, lockout, unlock timeout and PIN reprogramming.
- Drives status back to keypadDecode: 0 = keypad scanning/entry enabled, 1 = keypad frozen.

Parameters:
- DEFAULT_PIN, 16'h1234, stored PIN after reset.
- MAX_ATTEMPTS, 3, consecutive failures before lockout (1..15).
- FAIL_CYCLES, 500, FAIL_HOLD duration in clk_500Hz cycles (1 s).
- UNLOCK_CYCLES, 2500, auto-relock time (5 s).
- LOCKOUT_CYCLES, 15000, lockout duration (30 s).
- PROG_CYCLES, 5000, idle timeout in either programming state (10 s).

Ports:
- clk_500Hz  in  1  system clock (500 Hz scan clock).
- rst_n  in  1  asynchronous, active-low reset.
- validPin  in  1  one-cycle pulse: userPin holds a completed entry.
- userPin  in  16  entered PIN, {d0,d1,d2,d3}.
- setMode  in  1  level request to reprogram the PIN; synchronous, sampled each cycle.
- status  out  1  1 = keypad frozen.
- unlocked  out  1  lock actuator enable.
- lockedOut  out  1  high during LOCKOUT.
- attemptsLeft  out  4  remaining attempts.
- stateCode  out  3  current FSM state encoding, for the 7-segment display.
- progDone  out  1  one-cycle pulse: new PIN committed.
- progErr  out  1  one-cycle pulse: confirm mismatch, abort, or timeout.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=LOCKED, storedPin=DEFAULT_PIN, timer=0, attemptsLeft=MAX_ATTEMPTS.
  - status=0, unlocked=0, lockedOut=0, progDone=0, progErr=0, stateCode=0.
  - Reset mid-operation discards any captured or new PIN. storedPin is volatile.
- States and stateCode: LOCKED=0, CHECK=1, UNLOCKED=2, FAIL_HOLD=3, LOCKOUT=4, PROG_NEW=5, PROG_CONFIRM=6.
- Outputs are registered and change in the same cycle as the state register.
- status=0 in LOCKED, PROG_NEW and PROG_CONFIRM; status=1 in all other states.
- validPin is ignored in any state where status=1.
- Single down-counter timer, width $clog2(max timeout + 1).
  - Loaded on entry to any timed state.
  - Decrements each cycle; expiry is timer==0 while in that state.
- LOCKED:
  - On validPin: capture userPin into capReg, go to CHECK.
  - setMode is ignored in LOCKED.
- CHECK (exactly 1 cycle). Entry latency: validPin cycle → CHECK next cycle → result state the cycle after.
  - capReg==storedPin: go to UNLOCKED, attemptsLeft=MAX_ATTEMPTS, timer=UNLOCK_CYCLES-1.
  - Mismatch: attemptsLeft decrements.
    - If the new value is 0: go to LOCKOUT, timer=LOCKOUT_CYCLES-1.
    - Otherwise: go to FAIL_HOLD, timer=FAIL_CYCLES-1.
- FAIL_HOLD: on expiry go to LOCKED. attemptsLeft is unchanged.
- LOCKOUT:
  - lockedOut=1.
  - On expiry go to LOCKED, attemptsLeft=MAX_ATTEMPTS.
  - Reset is the only early exit.
- UNLOCKED:
  - unlocked=1.
  - If setMode=1: go to PROG_NEW, timer=PROG_CYCLES-1. setMode wins over a simultaneous expiry.
  - Otherwise, on expiry go to LOCKED.
- PROG_NEW:
  - unlocked stays 1.
  - setMode=0: abort (progErr pulse) and go to LOCKED.
  - On validPin: newReg=userPin, go to PROG_CONFIRM, timer reloaded.
  - On expiry: progErr pulse, go to LOCKED.
  - Priority: setMode drop > validPin > expiry.
- PROG_CONFIRM:
  - Same abort and timeout rules as PROG_NEW.
  - validPin with userPin==newReg: storedPin=newReg, progDone pulse, go to LOCKED.
  - validPin with mismatch: progErr pulse, go to LOCKED; storedPin unchanged.
- Programming never alters attemptsLeft.
- The FSM is never stuck: every non-LOCKED state has a timed or forced exit. Unused encodings go to LOCKED.

Decomposition:
- Shared package lock_pkg:
  - state enum/localparams (3-bit encoding above).
  - PIN_W=16.
  - BLANK_DIGIT=4'hF, for display reuse.
- One natural sub-module: lock_timer. Loadable down-counter with load, load_value and expired outputs, parameterised width.
- Comparators stay inline.

Test Plan (sim params: FAIL_CYCLES=4, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, PROG_CYCLES=10, MAX_ATTEMPTS=3):
- Correct PIN: validPin with userPin=16'h1234.
  - CHECK one cycle later; unlocked=1 and status=1 the following cycle.
  - After 8 cycles: unlocked=0, status=0, stateCode=0.
- Three wrong PINs (16'h0000), each after FAIL_HOLD clears:
  - attemptsLeft goes 2 then 1 (FAIL_HOLD for 4 cycles, status=1).
  - Third failure gives lockedOut=1 for 16 cycles.
  - Then attemptsLeft=3 and LOCKED.
- Frozen-input check: validPin pulsed during FAIL_HOLD, LOCKOUT and UNLOCKED → no state change, no capture.
- Reprogram:
  - Unlock, setMode=1, enter 16'h5678 twice → progDone pulse, LOCKED.
  - 16'h1234 then fails; 16'h5678 unlocks.
- Confirm mismatch: 16'h5678 then 16'h5679 → progErr pulse, storedPin unchanged.
- Abort/timeout/reset:
  - setMode drop in PROG_CONFIRM → progErr, LOCKED.
  - No entry for 10 cycles → progErr.
  - rst_n low mid-LOCKOUT → immediately LOCKED, attemptsLeft=3, storedPin=16'h1234.
